rvb_simple_issue: RTL

Registered issue stage directly upstream of `rvb_simple`. It accepts a raw 32-bit instruction word and three operand values, then decodes the instruction against the `rvb_simple` opcode set. For ADDIWU it substitutes the sign-extended immediate for rs2. It presents the result to `rvb_simple` as its `din_*` bundle through a two-entry skid buffer, so `in_ready` is fully registered and throughput is one instruction per cycle.

---
 rtl/rvb_simple_pkg.sv | 41 ++++
 rtl/rvb_simple_skid.sv | 77 +++++++
 rtl/rvb_simple_issue.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/rvb_simple_pkg.sv
// Shared opcode, funct and state definitions for the rvb_simple issue stage.
package rvb_simple_pkg;

    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;

    localparam logic [6:0] F7_MINMAX = 7'b0000101;
    localparam logic [6:0] F7_ANDN   = 7'b0100000;
    localparam logic [6:0] F7_PACK   = 7'b0000100;
    localparam logic [6:0] F7_PACKU  = 7'b0100100;
    localparam logic [6:0] F7_ADDWU  = 7'b0000101;
    localparam logic [6:0] F7_SUBWU  = 7'b0100101;
    localparam logic [6:0] F7_ADDUW  = 7'b0000100;
    localparam logic [6:0] F7_SUBUW  = 7'b0100100;
    localparam logic [6:0] F7_PACKW  = 7'b0000100;
    localparam logic [6:0] F7_PACKUW = 7'b0100100;

    localparam logic [2:0] F3_MIN    = 3'b100;
    localparam logic [2:0] F3_MAX    = 3'b101;
    localparam logic [2:0] F3_MINU   = 3'b110;
    localparam logic [2:0] F3_MAXU   = 3'b111;
    localparam logic [2:0] F3_ANDN   = 3'b111;
    localparam logic [2:0] F3_ORN    = 3'b110;
    localparam logic [2:0] F3_XNOR   = 3'b100;
    localparam logic [2:0] F3_PACK   = 3'b100;
    localparam logic [2:0] F3_PACKH  = 3'b111;
    localparam logic [2:0] F3_PACKU  = 3'b100;
    localparam logic [2:0] F3_CMIX   = 3'b001;
    localparam logic [2:0] F3_CMOV   = 3'b101;
    localparam logic [2:0] F3_ADDW   = 3'b000;
    localparam logic [2:0] F3_PACKW  = 3'b100;
    localparam logic [2:0] F3_ADDIWU = 3'b100;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/rvb_simple_skid.sv
// Two-entry skid buffer: main entry drives the outputs, skid entry absorbs
// the one extra beat accepted while in_ready is still high.
module rvb_simple_skid
    import rvb_simple_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state_q;
    logic         ready_q;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         push;
    logic         pop;

    assign push      = in_valid & ready_q;
    assign pop       = (state_q != EMPTY) & out_ready;
    assign in_ready  = ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
            ready_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            ready_q <= 1'b1;
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_q <= ONE;
                        main_q  <= in_data;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_q <= TWO;
                        skid_q  <= in_data;
                        ready_q <= 1'b0;
                    end else if (pop && !push) begin
                        state_q <= EMPTY;
                    end else if (push && pop) begin
                        main_q  <= in_data;
                    end
                end
                TWO: begin
                    // push cannot happen here: ready_q is low in TWO
                    if (pop) begin
                        state_q <= ONE;
                        main_q  <= skid_q;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/rvb_simple_issue.sv
// Issue stage ahead of rvb_simple: decodes the supported opcode set,
// substitutes the ADDIWU immediate, and registers through a skid buffer.
module rvb_simple_issue
    import rvb_simple_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_rs3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [XLEN-1:0] out_rs3,
    output logic            out_insn3,
    output logic            out_insn5,
    output logic            out_insn12,
    output logic            out_insn13,
    output logic            out_insn14,
    output logic            out_insn25,
    output logic            out_insn26,
    output logic            out_insn27,
    output logic            out_insn30,
    output logic            out_illegal
);

    localparam bit          RV64 = (XLEN == 64);
    localparam int unsigned W    = 10 + 3 * XLEN;

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            is_op;
    logic            is_op32;
    logic            is_addiwu;
    logic            legal;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_sel;
    logic [XLEN-1:0] rs2_sel;
    logic [XLEN-1:0] rs3_sel;
    logic [8:0]      bits_sel;
    logic [W-1:0]    din;
    logic [W-1:0]    dout;
    logic            unused_fields;

    assign opc = in_insn[6:0];
    assign f3  = in_insn[14:12];
    assign f7  = in_insn[31:25];
    assign imm = {{(XLEN-12){in_insn[31]}}, in_insn[31:20]};

    // register specifiers are not needed: operands arrive already read
    assign unused_fields = ^{in_insn[19:15], in_insn[11:7]};

    always_comb begin
        is_op     = 1'b0;
        is_op32   = 1'b0;
        is_addiwu = 1'b0;
        if (opc == OP) begin
            is_op = (f7 == F7_MINMAX
                     && (f3 == F3_MIN || f3 == F3_MAX
                      || f3 == F3_MINU || f3 == F3_MAXU))
                 || (f7 == F7_ANDN
                     && (f3 == F3_ANDN || f3 == F3_ORN
                      || f3 == F3_XNOR))
                 || (f7 == F7_PACK
                     && (f3 == F3_PACK || f3 == F3_PACKH))
                 || (f7 == F7_PACKU && f3 == F3_PACKU)
                 || (in_insn[26:25] == 2'b11
                     && (f3 == F3_CMIX || f3 == F3_CMOV));
        end
        if (RV64 && opc == OP_32) begin
            is_op32 = (f3 == F3_ADDW
                       && (f7 == F7_ADDWU || f7 == F7_SUBWU
                        || f7 == F7_ADDUW || f7 == F7_SUBUW))
                   || (f3 == F3_PACKW
                       && (f7 == F7_PACKW || f7 == F7_PACKUW));
        end
        if (RV64 && opc == OP_IMM_32) begin
            is_addiwu = (f3 == F3_ADDIWU);
        end
    end

    assign legal = is_op | is_op32 | is_addiwu;

    always_comb begin
        rs1_sel  = '0;
        rs2_sel  = '0;
        rs3_sel  = '0;
        bits_sel = '0;
        unique case (1'b1)
            !legal: begin
                rs1_sel = '0;
            end
            is_addiwu: begin
                rs1_sel  = in_rs1;
                rs2_sel  = imm;
                rs3_sel  = in_rs3;
                bits_sel = {in_insn[3], in_insn[5], in_insn[12],
                            in_insn[13], in_insn[14], in_insn[25],
                            in_insn[26], in_insn[27], in_insn[30]};
            end
            default: begin
                rs1_sel  = in_rs1;
                rs2_sel  = in_rs2;
                rs3_sel  = in_rs3;
                bits_sel = {in_insn[3], in_insn[5], in_insn[12],
                            in_insn[13], in_insn[14], in_insn[25],
                            in_insn[26], in_insn[27], in_insn[30]};
            end
        endcase
    end

    assign din = {~legal, bits_sel, rs1_sel, rs2_sel, rs3_sel};

    rvb_simple_skid #(
        .W (W)
    ) u_skid (
        .clock     (clock),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (dout)
    );

    assign {out_illegal,
            out_insn3, out_insn5, out_insn12, out_insn13, out_insn14,
            out_insn25, out_insn26, out_insn27, out_insn30,
            out_rs1, out_rs2, out_rs3} = dout;

endmodule
